// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and decode helper for the HI/LO unit
package muldiv_pkg;
  localparam int DIV_ITERATIONS = 32;
  typedef enum logic [3:0] {
    MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_ITER, DIV_FIX} state_t;
  typedef struct packed {
    logic valid;
    muldiv_op_t op;
  } muldiv_dec_t;
  // SPECIAL (opcode 0) and SPECIAL2 (opcode 0x1c) function codes
  function automatic muldiv_dec_t muldiv_decode(input logic [5:0] opcode, input logic [5:0] funct);
    muldiv_dec_t d;
    d.valid = 1'b1;
    d.op = MULT;
    if (opcode == 6'h00) begin
      case (funct)
        6'h18: d.op = MULT;
        6'h19: d.op = MULTU;
        6'h1a: d.op = DIV;
        6'h1b: d.op = DIVU;
        6'h11: d.op = MTHI;
        6'h13: d.op = MTLO;
        default: d.valid = 1'b0;
      endcase
    end else if (opcode == 6'h1c) begin
      case (funct)
        6'h00: d.op = MADD;
        6'h01: d.op = MADDU;
        6'h04: d.op = MSUB;
        6'h05: d.op = MSUBU;
        default: d.valid = 1'b0;
      endcase
    end else d.valid = 1'b0;
    return d;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step: one restoring shift/subtract step on a {remainder, quotient} pair
module div_step (
  input  logic [63:0] pr,
  input  logic [31:0] divisor,
  output logic [63:0] rem,
  output logic        q
);
  logic [32:0] sh, diff;
  assign sh = pr[63:31];
  assign diff = sh - {1'b0, divisor};
  assign q = ~diff[32];
  assign rem = {q ? diff[31:0] : sh[31:0], pr[30:0], 1'b0};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle HI/LO multiply, accumulate, divide and move unit
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  state_t state, state_n;
  muldiv_op_t op_r;
  logic [4:0] cnt;
  logic signed [32:0] a_r, b_r;
  logic signed [65:0] prod, prod_out;
  logic [63:0] pr, rem, mul_res, hilo;
  logic [31:0] dvs;
  logic neg_q, neg_r, q, accept, is_div, is_mt, is_mul, is_signed, rt_zero, mul_last, div_last, unused;

  assign is_div = op == DIV || op == DIVU;
  assign is_mt = op == MTHI || op == MTLO;
  assign is_mul = op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  assign is_signed = op inside {MULT, DIV, MADD, MSUB};
  assign rt_zero = rt_data == '0;
  assign accept = start && !flush && state == IDLE;
  assign mul_last = state == MUL_WAIT && cnt == 5'(MUL_CYCLES - 1);
  assign div_last = state == DIV_ITER && cnt == 5'(DIV_ITERATIONS - 1);
  assign busy = state != IDLE;
  assign hilo = {hi, lo};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !accept ? IDLE : is_div ? (rt_zero ? DIV_FIX : DIV_ITER) : is_mul ? MUL_WAIT : IDLE;
      MUL_WAIT: state_n = mul_last ? IDLE : MUL_WAIT;
      DIV_ITER: state_n = div_last ? DIV_FIX : DIV_ITER;
      default:  state_n = IDLE;
    endcase
    if (flush && busy) state_n = IDLE;
  end

  always_ff @(posedge clock) state <= reset ? IDLE : state_n;

  // operands stay latched through MUL_WAIT, so the delay chain is free to be retimed
  assign prod = a_r * b_r;
  if (MUL_CYCLES == 1) begin : g_mul_comb
    assign prod_out = prod;
  end else begin : g_mul_pipe
    logic signed [65:0] pipe [MUL_CYCLES-1];
    always_ff @(posedge clock) begin
      pipe[0] <= prod;
      for (int i = 1; i < MUL_CYCLES - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign prod_out = pipe[MUL_CYCLES-2];
  end
  assign unused = ^prod_out[65:64];
  assign mul_res = (op_r == MADD || op_r == MADDU) ? hilo + prod_out[63:0] :
                   (op_r == MSUB || op_r == MSUBU) ? hilo - prod_out[63:0] : prod_out[63:0];

  div_step u_step (.pr(pr), .divisor(dvs), .rem(rem), .q(q));

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      cnt <= (busy && state_n == state) ? cnt + 5'd1 : '0;
      if (accept) begin
        op_r <= op;
        a_r <= {is_signed & rs_data[31], rs_data};
        b_r <= {is_signed & rt_data[31], rt_data};
        dvs <= (is_signed && rt_data[31]) ? -rt_data : rt_data;
        // a zero divisor preloads the final answer and bypasses the iterations
        pr <= rt_zero ? {rs_data, 32'hFFFF_FFFF} : {32'h0, (is_signed && rs_data[31]) ? -rs_data : rs_data};
        neg_q <= is_signed && !rt_zero && (rs_data[31] ^ rt_data[31]);
        neg_r <= is_signed && !rt_zero && rs_data[31];
        hi <= op == MTHI ? rs_data : hi;
        lo <= op == MTLO ? rs_data : lo;
        done <= is_mt;
      end
      if (state == DIV_ITER) pr <= {rem[63:1], q};
      if (mul_last && !flush) begin
        {hi, lo} <= mul_res;
        done <= 1'b1;
      end
      if (state == DIV_FIX && !flush) begin
        hi <= neg_r ? -pr[63:32] : pr[63:32];
        lo <= neg_q ? -pr[31:0] : pr[31:0];
        done <= 1'b1;
      end
    end
  end

  a_start_while_busy: assert property (@(posedge clock) disable iff (reset) !(start && busy));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table, corner-sequence and random checks against an arithmetic model
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  localparam int MC = 3;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  muldiv_op_t op = MULT;
  logic [31:0] rs_data = '0, rt_data = '0, hi, lo;
  logic busy, done;
  int checks = 0, errors = 0;
  logic [63:0] model_hilo = '0;

  muldiv_sequencer #(.MUL_CYCLES(MC)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    muldiv_op_t op;
    logic [31:0] a, b;
    logic [63:0] res;
    int lat;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] sp = sa * sb;
    logic [63:0] up = {32'h0, a} * {32'h0, b};
    longint qq, rr;
    case (o)
      MULT:  return sp;
      MULTU: return up;
      MADD:  return acc + sp;
      MADDU: return acc + up;
      MSUB:  return acc - sp;
      MSUBU: return acc - up;
      MTHI:  return {a, acc[31:0]};
      MTLO:  return {acc[63:32], a};
      DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        qq = sa / sb;
        rr = sa % sb;
        return {rr[31:0], qq[31:0]};
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  function automatic int ref_lat(input muldiv_op_t o, input logic [31:0] b);
    if (o == MTHI || o == MTLO) return 1;
    if (o == DIV || o == DIVU) return b == 0 ? 2 : 34;
    return MC + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // called at a negedge; starts immediately, so consecutive calls are back-to-back
  task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input int elat, input logic [63:0] eres, input string nm);
    int n;
    bit bad;
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    bad = 0;
    while (!done && n < 60) begin
      if (!busy || {hi, lo} !== model_hilo) bad = 1;
      @(negedge clock);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " busy/hold"}, {63'h0, bad | busy}, 64'h0);
    chk({nm, " hilo"}, {hi, lo}, eres);
    model_hilo = eres;
  endtask

  initial begin
    bit saw_done;
    tv[0]  = '{MTHI,  32'h0,         32'h0,         64'h0000_0000_0000_0000, 1};
    tv[1]  = '{MTLO,  32'hFFFF_FFFF, 32'h0,         64'h0000_0000_FFFF_FFFF, 1};
    tv[2]  = '{MADD,  32'h1,         32'h1,         64'h0000_0001_0000_0000, 4};
    tv[3]  = '{MSUB,  32'h1,         32'h1,         64'h0000_0000_FFFF_FFFF, 4};
    tv[4]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4};
    tv[5]  = '{DIV,   32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD, 34};
    tv[6]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34};
    tv[7]  = '{DIVU,  32'h5,         32'h0,         64'h0000_0005_FFFF_FFFF, 2};
    tv[8]  = '{DIV,   32'hFFFF_FFF9, 32'h0,         64'hFFFF_FFF9_FFFF_FFFF, 2};
    tv[9]  = '{MULT,  32'hFFFF_FFFD, 32'h5,         64'hFFFF_FFFF_FFFF_FFF1, 4};
    tv[10] = '{DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 34};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset hilo", {hi, lo}, 64'h0);
    chk("reset busy/done", {62'h0, busy, done}, 64'h0);
    for (int i = 0; i < 11; i++)
      do_op(tv[i].op, tv[i].a, tv[i].b, tv[i].lat, tv[i].res, $sformatf("tv%0d", i));

    // flush of a divide in cycle 10, then a multiply started in cycle 11
    start = 1'b1; op = DIV; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clock);
    start = 1'b0;
    saw_done = 0;
    repeat (9) begin
      saw_done |= done;
      @(negedge clock);
    end
    chk("flush pre busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush busy/done", {61'h0, saw_done, busy, done}, 64'h0);
    chk("flush hilo", {hi, lo}, model_hilo);
    do_op(MULT, 32'd7, 32'hFFFF_FFFE, MC + 1, 64'hFFFF_FFFF_FFFF_FFF2, "post-flush mult");

    // flush wins over a simultaneous start in IDLE
    start = 1'b1; flush = 1'b1; op = MTHI; rs_data = 32'hDEAD_BEEF;
    @(negedge clock);
    op = DIV; rt_data = 32'd9;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy/done", {62'h0, busy, done}, 64'h0);
    chk("flush+start hilo", {hi, lo}, model_hilo);

    // reset in cycle 5 of a divide
    start = 1'b1; op = DIV; rs_data = 32'd100; rt_data = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_hilo = '0;
    chk("mid reset hilo", {hi, lo}, 64'h0);
    chk("mid reset busy/done", {62'h0, busy, done}, 64'h0);
    @(negedge clock);
    chk("post reset busy/done", {62'h0, busy, done}, 64'h0);

    for (int i = 0; i < 200; i++) begin
      muldiv_op_t o;
      logic [31:0] a, b;
      o = muldiv_op_t'(4'($urandom_range(0, 9)));
      a = pick();
      b = pick();
      do_op(o, a, b, ref_lat(o, b), ref_op(o, a, b, model_hilo), $sformatf("rnd%0d %s", i, o.name()));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
